// File: rtl/imem_arbiter.sv
// Two-requester (fetch, loader) arbiter for a single-ported instruction memory.
// One transaction in flight; round-robin on ties; read responses bounded by a timeout.
module imem_arbiter #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  f_req_valid,
   output logic                  f_req_ready,
   input  logic [ADDR_WIDTH-1:0] f_req_addr,
   output logic                  f_rsp_valid,
   input  logic                  f_rsp_ready,
   output logic [DATA_WIDTH-1:0] f_rsp_data,
   output logic                  f_rsp_err,
   input  logic                  l_req_valid,
   output logic                  l_req_ready,
   input  logic [ADDR_WIDTH-1:0] l_req_addr,
   input  logic                  l_req_we,
   input  logic [DATA_WIDTH-1:0] l_req_wdata,
   output logic                  l_rsp_valid,
   input  logic                  l_rsp_ready,
   output logic [DATA_WIDTH-1:0] l_rsp_data,
   output logic                  l_rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_last_l;
   logic                  r_owner_l;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_mem_en;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_rsp_err;

   logic w_idle;
   logic w_grant_f;
   logic w_grant_l;
   logic w_accept;
   logic w_rsp_ready;
   logic w_timeout;

   // Ties go to whoever was not served last; r_last_l=1 means the loader was.
   assign w_idle      = rst & (r_state == S_IDLE);
   assign w_grant_f   = f_req_valid & (~l_req_valid | r_last_l);
   assign w_grant_l   = l_req_valid & (~f_req_valid | ~r_last_l);
   assign f_req_ready = w_idle & w_grant_f;
   assign l_req_ready = w_idle & w_grant_l;
   assign w_accept    = f_req_ready | l_req_ready;
   assign w_rsp_ready = r_owner_l ? l_rsp_ready : f_rsp_ready;
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   // One shared response register, steered to the owning requester.
   assign f_rsp_valid = r_rsp_valid & ~r_owner_l;
   assign f_rsp_data  = r_owner_l ? '0 : r_rsp_data;
   assign f_rsp_err   = r_rsp_err & ~r_owner_l;
   assign l_rsp_valid = r_rsp_valid & r_owner_l;
   assign l_rsp_data  = r_owner_l ? r_rsp_data : '0;
   assign l_rsp_err   = r_rsp_err & r_owner_l;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_last_l    <= 1'b1;
         r_owner_l   <= 1'b0;
         r_cnt       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_owner_l   <= l_req_ready;
                  r_mem_addr  <= l_req_ready ? l_req_addr : f_req_addr;
                  r_mem_we    <= l_req_ready & l_req_we;
                  r_mem_wdata <= l_req_ready ? l_req_wdata : '0;
                  r_mem_en    <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               r_cnt    <= '0;
               if (r_mem_we) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= mem_rdata;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               if (w_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b0;
                  r_last_l    <= r_owner_l;
                  r_cnt       <= '0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, hand-built corner sequences,
// and a randomized run against a transaction-level timing model.
module tb_imem_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned T  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
   logic [AW-1:0] f_req_addr;
   logic [DW-1:0] f_rsp_data;
   logic          l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready, l_rsp_err;
   logic [AW-1:0] l_req_addr;
   logic [DW-1:0] l_req_wdata, l_rsp_data;
   logic [AW-1:0] mem_addr;
   logic          mem_en, mem_we, mem_rvalid;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
      .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
      .f_rsp_err(f_rsp_err),
      .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_addr(l_req_addr),
      .l_req_we(l_req_we), .l_req_wdata(l_req_wdata),
      .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready), .l_rsp_data(l_rsp_data),
      .l_rsp_err(l_rsp_err),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic fv; logic [31:0] fa; logic lv; logic lwe; logic [31:0] la; logic [31:0] lwd;
      logic rv; logic [31:0] rd; logic frr; logic lrr;
      logic efr; logic elr; logic een; logic ewe; logic [31:0] eaddr; logic [31:0] ewd;
      logic efv; logic [31:0] efd; logic elv; logic [31:0] eld;
   } vec_t;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clr_in();
      f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b0;
      l_req_valid = 1'b0; l_req_we = 1'b0; l_req_addr = '0; l_req_wdata = '0; l_rsp_ready = 1'b0;
      mem_rdata = '0; mem_rvalid = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk1({nm, " f_req_ready"}, f_req_ready, 1'b0);
      chk1({nm, " l_req_ready"}, l_req_ready, 1'b0);
      chk1({nm, " mem_en"}, mem_en, 1'b0);
      chk1({nm, " mem_we"}, mem_we, 1'b0);
      chk32({nm, " mem_addr"}, mem_addr, 32'h0);
      chk32({nm, " mem_wdata"}, mem_wdata, 32'h0);
      chk1({nm, " f_rsp_valid"}, f_rsp_valid, 1'b0);
      chk1({nm, " l_rsp_valid"}, l_rsp_valid, 1'b0);
      chk32({nm, " f_rsp_data"}, f_rsp_data, 32'h0);
      chk32({nm, " l_rsp_data"}, l_rsp_data, 32'h0);
      chk1({nm, " f_rsp_err"}, f_rsp_err, 1'b0);
      chk1({nm, " l_rsp_err"}, l_rsp_err, 1'b0);
   endtask

   task automatic drive_own(input bit is_l, input bit we, input logic [31:0] addr, input logic [31:0] wd);
      if (is_l) begin
         l_req_valid = 1'b1; l_req_we = we; l_req_addr = addr; l_req_wdata = wd;
      end else begin
         f_req_valid = 1'b1; f_req_addr = addr;
      end
   endtask

   task automatic drive_other(input bit is_l);
      if (is_l) begin
         f_req_valid = 1'b1; f_req_addr = 32'hF0F0_0000;
      end else begin
         l_req_valid = 1'b1; l_req_we = 1'b1; l_req_addr = 32'h0F0F_0000; l_req_wdata = 32'h5555_AAAA;
      end
   endtask

   // One complete transaction; latency and payload expectations come from the turnaround rules.
   task automatic txn(input bit is_l, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input int rv_d, input logic [31:0] rdata, input int hold,
                      input bit oth_wait, input bit oth_acc, input string nm);
      int lat; int t; bit seen; logic [31:0] edata; logic eerr;
      if (we) begin
         lat = 2; edata = 32'h0; eerr = 1'b0;
      end else if (rv_d >= 0 && rv_d < int'(T)) begin
         lat = 3 + rv_d; edata = rdata; eerr = 1'b0;
      end else begin
         lat = 2 + int'(T); edata = 32'h0; eerr = 1'b1;
      end
      tick(); clr_in(); drive_own(is_l, we, addr, wd);
      if (oth_acc) drive_other(is_l);
      #1;
      chk1({nm, " own ready"}, is_l ? l_req_ready : f_req_ready, 1'b1);
      chk1({nm, " other ready"}, is_l ? f_req_ready : l_req_ready, 1'b0);
      seen = 1'b0; t = 0;
      while (!seen && t < lat + 8) begin
         t++;
         tick(); clr_in();
         if (oth_wait) drive_other(is_l);
         if (t == 1) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
         end
         if (!we && rv_d >= 0 && t == 2 + rv_d) begin
            mem_rvalid = 1'b1; mem_rdata = rdata;
         end
         #1;
         chk1({nm, " mem_en"}, mem_en, (t == 1));
         if (t == 1) begin
            chk32({nm, " mem_addr"}, mem_addr, addr);
            chk1({nm, " mem_we"}, mem_we, we);
            if (we) chk32({nm, " mem_wdata"}, mem_wdata, wd);
         end
         chk1({nm, " busy f_req_ready"}, f_req_ready, 1'b0);
         chk1({nm, " busy l_req_ready"}, l_req_ready, 1'b0);
         chk1({nm, " other rsp_valid"}, is_l ? f_rsp_valid : l_rsp_valid, 1'b0);
         seen = is_l ? l_rsp_valid : f_rsp_valid;
      end
      chk32({nm, " latency"}, 32'(t), 32'(lat));
      chk32({nm, " rsp_data"}, is_l ? l_rsp_data : f_rsp_data, edata);
      chk1({nm, " rsp_err"}, is_l ? l_rsp_err : f_rsp_err, eerr);
      for (int h = 0; h <= hold; h++) begin
         tick(); clr_in();
         if (oth_wait && h < hold) drive_other(is_l);
         if (h == hold) begin
            if (is_l) l_rsp_ready = 1'b1; else f_rsp_ready = 1'b1;
         end
         #1;
         chk1({nm, " held rsp_valid"}, is_l ? l_rsp_valid : f_rsp_valid, 1'b1);
         chk32({nm, " held rsp_data"}, is_l ? l_rsp_data : f_rsp_data, edata);
         chk1({nm, " held rsp_err"}, is_l ? l_rsp_err : f_rsp_err, eerr);
         chk1({nm, " held other ready"}, is_l ? f_req_ready : l_req_ready, 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, want finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      bit m_busy, m_last_l, m_owner_l, m_we, g_f, g_l, e_en, e_v;
      logic [31:0] m_addr, m_wdata, m_edata;
      logic m_eerr;
      int m_acc, m_rsp, m_rv, k;

      // fv fa lv lwe la lwd rv rd frr lrr | efr elr een ewe eaddr ewd efv efd elv eld
      tbl.push_back('{1'b1,32'h10,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,32'h10,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b1,32'hDEADBEEF,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,32'hDEADBEEF,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b1,1'b1,32'h4,32'h12345678,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,32'h4,32'h12345678,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b1,32'h0});
      tbl.push_back('{1'b1,32'h20,1'b1,1'b1,32'h30,32'hA5,1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b1,1'b1,32'h30,32'hA5,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,32'h20,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b1,1'b1,32'h30,32'hA5,1'b1,32'h11111111,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b1,1'b1,32'h30,32'hA5,1'b0,32'h0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,32'h11111111,1'b0,32'h0});
      tbl.push_back('{1'b1,32'h24,1'b1,1'b1,32'h30,32'hA5,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b1,32'h24,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,32'h30,32'hA5,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b1,32'h24,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b1,32'h0});
      tbl.push_back('{1'b1,32'h24,1'b1,1'b1,32'h34,32'h5A,1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b1,1'b1,32'h34,32'h5A,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,32'h24,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b1,1'b1,32'h34,32'h5A,1'b1,32'h22,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b1,1'b1,32'h34,32'h5A,1'b0,32'h0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,32'h22,1'b0,32'h0});
      tbl.push_back('{1'b1,32'h28,1'b1,1'b1,32'h34,32'h5A,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,32'h34,32'h5A,1'b0,32'h0,1'b0,32'h0});
      tbl.push_back('{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b1,32'h0});

      // Reset with requests pending: everything quiet
      clr_in();
      rst = 1'b0; f_req_valid = 1'b1; l_req_valid = 1'b1; mem_rvalid = 1'b1;
      tick(); tick(); #1;
      chk_zero("reset");
      tick(); rst = 1'b1; clr_in();

      foreach (tbl[i]) begin
         tick();
         f_req_valid = tbl[i].fv; f_req_addr = tbl[i].fa;
         l_req_valid = tbl[i].lv; l_req_we = tbl[i].lwe; l_req_addr = tbl[i].la; l_req_wdata = tbl[i].lwd;
         mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rd;
         f_rsp_ready = tbl[i].frr; l_rsp_ready = tbl[i].lrr;
         #1;
         chk1($sformatf("tbl%0d f_req_ready", i), f_req_ready, tbl[i].efr);
         chk1($sformatf("tbl%0d l_req_ready", i), l_req_ready, tbl[i].elr);
         chk1($sformatf("tbl%0d mem_en", i), mem_en, tbl[i].een);
         if (tbl[i].een) begin
            chk32($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].eaddr);
            chk1($sformatf("tbl%0d mem_we", i), mem_we, tbl[i].ewe);
            if (tbl[i].ewe) chk32($sformatf("tbl%0d mem_wdata", i), mem_wdata, tbl[i].ewd);
         end
         chk1($sformatf("tbl%0d f_rsp_valid", i), f_rsp_valid, tbl[i].efv);
         chk1($sformatf("tbl%0d l_rsp_valid", i), l_rsp_valid, tbl[i].elv);
         if (tbl[i].efv) begin
            chk32($sformatf("tbl%0d f_rsp_data", i), f_rsp_data, tbl[i].efd);
            chk1($sformatf("tbl%0d f_rsp_err", i), f_rsp_err, 1'b0);
         end
         if (tbl[i].elv) begin
            chk32($sformatf("tbl%0d l_rsp_data", i), l_rsp_data, tbl[i].eld);
            chk1($sformatf("tbl%0d l_rsp_err", i), l_rsp_err, 1'b0);
         end
      end

      // Timeout, recovery, and rvalid on the last allowed WAIT cycle
      txn(1'b0, 1'b0, 32'h40, 32'h0, -1, 32'h0, 0, 1'b0, 1'b0, "timeout");
      txn(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h3333_3333, 0, 1'b0, 1'b0, "after_timeout");
      txn(1'b0, 1'b0, 32'h48, 32'h0, int'(T) - 1, 32'h4444_4444, 0, 1'b0, 1'b0, "last_wait_cycle");

      // Response backpressure with the loader waiting, then loader served right after
      txn(1'b0, 1'b0, 32'h50, 32'h0, 0, 32'hCAFE_F00D, 5, 1'b1, 1'b0, "backpressure");
      txn(1'b1, 1'b1, 32'h60, 32'h77, -1, 32'h0, 0, 1'b0, 1'b0, "bp_next");

      // Reset in WAIT: abort silently, arbitration restarts with fetch winning
      txn(1'b0, 1'b0, 32'h70, 32'h0, 1, 32'h99, 0, 1'b0, 1'b0, "pre_reset");
      tick(); clr_in(); l_req_valid = 1'b1; l_req_addr = 32'h80; #1;
      chk1("rst_seq l_req_ready", l_req_ready, 1'b1);
      tick(); clr_in(); #1;
      chk1("rst_seq mem_en", mem_en, 1'b1);
      tick(); clr_in(); #1;
      chk1("rst_seq wait l_rsp_valid", l_rsp_valid, 1'b0);
      tick(); rst = 1'b0; f_req_valid = 1'b1; l_req_valid = 1'b1; #1;
      chk_zero("rst_in_wait");
      tick();
      tick(); rst = 1'b1; clr_in();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin tick(); clr_in(); end
         if (i == 0) begin mem_rvalid = 1'b1; mem_rdata = 32'hBADB_AD00; end
         #1;
         chk1("post_rst l_rsp_valid", l_rsp_valid, 1'b0);
         chk1("post_rst f_rsp_valid", f_rsp_valid, 1'b0);
         chk1("post_rst mem_en", mem_en, 1'b0);
      end
      txn(1'b0, 1'b0, 32'h90, 32'h0, 0, 32'h1234, 0, 1'b0, 1'b1, "post_rst_grant");

      // Randomized run against a transaction-level timing model
      tick(); rst = 1'b0; clr_in();
      tick(); rst = 1'b1;
      m_busy = 1'b0; m_last_l = 1'b1; m_owner_l = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_edata = '0; m_eerr = 1'b0;
      m_acc = -100; m_rsp = -100; m_rv = -100;
      for (int c = 0; c < 1500; c++) begin
         tick();
         f_req_valid = 1'($urandom_range(0, 1)); f_req_addr = $urandom;
         l_req_valid = 1'($urandom_range(0, 1)); l_req_we = 1'($urandom_range(0, 1));
         l_req_addr = $urandom; l_req_wdata = $urandom;
         f_rsp_ready = ($urandom_range(0, 2) != 0); l_rsp_ready = ($urandom_range(0, 2) != 0);
         mem_rdata = $urandom;
         if (m_busy && !m_we && c == m_rv) begin
            mem_rvalid = 1'b1; m_edata = mem_rdata;
         end else if (!m_busy || c < m_acc + 2 || c >= m_rsp) begin
            mem_rvalid = ($urandom_range(0, 3) == 0);
         end else begin
            mem_rvalid = 1'b0;
         end
         #1;
         g_f = !m_busy && f_req_valid && (!l_req_valid || m_last_l);
         g_l = !m_busy && l_req_valid && (!f_req_valid || !m_last_l);
         chk1("rnd f_req_ready", f_req_ready, g_f);
         chk1("rnd l_req_ready", l_req_ready, g_l);
         e_en = m_busy && c == m_acc + 1;
         chk1("rnd mem_en", mem_en, e_en);
         if (e_en) begin
            chk32("rnd mem_addr", mem_addr, m_addr);
            chk1("rnd mem_we", mem_we, m_we);
            if (m_we) chk32("rnd mem_wdata", mem_wdata, m_wdata);
         end
         e_v = m_busy && c >= m_rsp;
         chk1("rnd f_rsp_valid", f_rsp_valid, e_v && !m_owner_l);
         chk1("rnd l_rsp_valid", l_rsp_valid, e_v && m_owner_l);
         if (e_v) begin
            chk32("rnd rsp_data", m_owner_l ? l_rsp_data : f_rsp_data, m_edata);
            chk1("rnd rsp_err", m_owner_l ? l_rsp_err : f_rsp_err, m_eerr);
         end
         if (e_v && (m_owner_l ? l_rsp_ready : f_rsp_ready)) begin
            m_busy = 1'b0; m_last_l = m_owner_l;
         end else if (g_f || g_l) begin
            m_busy = 1'b1; m_owner_l = g_l; m_acc = c;
            m_addr = g_l ? l_req_addr : f_req_addr;
            m_we = g_l && l_req_we; m_wdata = l_req_wdata;
            m_edata = 32'h0; m_eerr = 1'b0; m_rv = -100;
            if (m_we) begin
               m_rsp = c + 2;
            end else begin
               k = int'($urandom_range(0, T + 3));
               if (k < int'(T)) begin
                  m_rv = c + 2 + k; m_rsp = c + 3 + k;
               end else begin
                  m_rsp = c + 2 + int'(T); m_eerr = 1'b1;
               end
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of instruction/data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, word-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait for a memory read response (range 1..255).
REQ-004 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- f_req_valid  in  1  fetch requester read request
- f_req_ready  out  1  fetch request accepted
- f_req_addr  in  ADDR_WIDTH  fetch word address
- f_rsp_valid  out  1  fetch response available
- f_rsp_ready  in  1  fetch requester takes response
- f_rsp_data  out  DATA_WIDTH  fetch read data
- f_rsp_err  out  1  fetch response is a timeout
- l_req_valid  in  1  loader requester request
- l_req_ready  out  1  loader request accepted
- l_req_addr  in  ADDR_WIDTH  loader word address
- l_req_we  in  1  1 = write, 0 = read
- l_req_wdata  in  DATA_WIDTH  loader write data
- l_rsp_valid  out  1  loader response available
- l_rsp_ready  in  1  loader takes response
- l_rsp_data  out  DATA_WIDTH  loader read data (0 for writes)
- l_rsp_err  out  1  loader response is a timeout
- mem_addr  out  ADDR_WIDTH  memory address
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_rvalid  in  1  mem_rdata valid

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-006 In IDLE, SHALL assert combinationally the ready of the granted requester only; grant: if one valid, that one; if both valid, the requester not served last (round-robin, last_grant initialised to loader so fetch wins first tie).
REQ-007 On accept (valid & ready in IDLE), SHALL latch address, we (0 for fetch), wdata and owner, and go to ISSUE next cycle.
REQ-008 In ISSUE, SHALL drive mem_en=1 for exactly one cycle with latched mem_addr/mem_we/mem_wdata; mem_en SHALL be 0 in all other states.
REQ-009 After ISSUE, a write SHALL go directly to RESP with data 0, err 0; a read SHALL go to WAIT.
REQ-010 In WAIT, SHALL capture mem_rdata on the first cycle with mem_rvalid=1 and go to RESP with err 0; mem_rvalid outside WAIT SHALL be ignored.
REQ-011 WAIT SHALL count cycles; if mem_rvalid not seen within TIMEOUT_CYCLES cycles, SHALL go to RESP with data 0, err 1.
REQ-012 In RESP, SHALL hold owner's rsp_valid=1 with stable data/err until owner's rsp_ready=1; on that edge SHALL update last_grant to owner and return to IDLE.
REQ-013 Minimum turnaround SHALL be: accept cycle N, mem_en cycle N+1, rsp_valid earliest N+2 (write) or N+3 (read with rvalid at N+2).
REQ-014 Non-owner rsp_valid SHALL be 0; both req_ready SHALL be 0 outside IDLE.
REQ-015 A request deasserted before accept SHALL be dropped without side effects; requests not accepted SHALL see no memory activity.
REQ-016 Address SHALL pass unmodified; no wrap or arithmetic in this block.

Reset
REQ-017 While rst=0: state IDLE, last_grant=loader, timeout counter 0, all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, both req_ready, both rsp_valid/data/err), asynchronously.
REQ-018 Reset mid-transaction SHALL abort it with no response; first grant after release SHALL follow REQ-006.

Verification
REQ-019 Fetch read alone: f_req_valid, addr 0x10 at cycle N, mem_rvalid with 0xDEADBEEF at N+2 -> mem_en at N+1 with mem_addr 0x10, f_rsp_valid/data 0xDEADBEEF at N+3, err 0.
REQ-020 Simultaneous requests repeated 4 times -> grants alternate F, L, F, L; no starvation.
REQ-021 Loader write addr 0x4, data 0x12345678 -> mem_en=mem_we=1 one cycle, l_rsp_valid next cycle, data 0, err 0, no fetch response.
REQ-022 Read with mem_rvalid never asserted, TIMEOUT_CYCLES=16 -> rsp_valid with err 1, data 0 after 16 WAIT cycles; next request served normally.
REQ-023 f_rsp_ready held 0 for 5 cycles -> f_rsp_valid/data stable, l_req_ready 0 throughout; released -> IDLE next cycle.
REQ-024 rst=0 asserted during WAIT -> all outputs 0 immediately; late mem_rvalid after release produces no response.
